dsp_rr_arbiter: RTL and testbench
=================================

// Module: dsp_rr_arbiter
// PURPOSE
// - Shares one combinational dsp_slice (result = a*b + c, unsigned) among NUM_REQ requesters.
// - Round-robin arbitration with per-requester valid/ready, registered operands to the slice,
//   and a single registered response channel tagged with the requester id.
// - Sits between the requesters and one dsp_slice instance; the slice is instantiated outside this block.
// PARAMETERS
// - data_width  8  operand width; the result is 2*data_width bits
// - NUM_REQ     4  number of requesters, >=2; ID_W = $clog2(NUM_REQ)
// PORTS
// - clk          in   1                    clock, rising edge
// - rst_n        in   1                    asynchronous active-low reset
// - req_valid    in   NUM_REQ              requester i has an operation pending
// - req_ready    out  NUM_REQ              one-hot: requester i accepted this cycle
// - req_a        in   NUM_REQ*data_width   operand a, requester i at [i*data_width +: data_width]
// - req_b        in   NUM_REQ*data_width   operand b, same packing
// - req_c        in   NUM_REQ*data_width   addend c, same packing
// - dsp_a        out  data_width           registered operand to dsp_slice.a
// - dsp_b        out  data_width           registered operand to dsp_slice.b
// - dsp_c        out  data_width           registered operand to dsp_slice.c
// - dsp_result   in   2*data_width         dsp_slice.result
// - resp_valid   out  1                    response available
// - resp_ready   in   1                    consumer accepts the response
// - resp_id      out  ID_W                 requester that issued the response
// - resp_result  out  2*data_width         captured dsp_result
// BEHAVIOUR
// - FSM states IDLE, EXEC, RESP. Reset: state=IDLE, rr_ptr=0, dsp_a/b/c=0, resp_valid=0,
//   resp_id=0, resp_result=0. req_ready is 0 in reset and in every state except IDLE.
// - IDLE: if any req_valid, winner = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   req_ready[winner]=1 combinationally in that same cycle (only that bit). On the clock edge: latch
//   the winner's a/b/c into dsp_a/b/c, latch the winner id, go to EXEC. No req_valid: stay in IDLE.
// - EXEC (1 cycle): dsp_result is settled from the registered operands; capture it into resp_result,
//   the id into resp_id, set resp_valid=1, go to RESP.
// - RESP: hold resp_valid, resp_id and resp_result stable while resp_ready=0. The response
//   transfers on a clock edge where resp_valid && resp_ready: clear resp_valid,
//   rr_ptr = (id+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0), go to IDLE.
// - Latency: accept to resp_valid = 2 cycles. Peak throughput: 1 op per 3 cycles (RESP->IDLE).
// - A requester must hold valid/a/b/c until its ready bit is high. Dropping valid before grant is
//   legal and discards nothing.
// - dsp_a/b/c keep their last values outside EXEC; there is no clearing between ops.
// - Arithmetic: no truncation. 2*data_width bits hold (2^dw-1)^2 + (2^dw-1) exactly;
//   resp_result = dsp_result.
// - Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all
//   registers return to their reset values asynchronously.
// CONFIGURATION
// - DSP_ARB_PRIO_EN defined: requester 0 has strict priority. If req_valid[0] is set in IDLE, it
//   wins regardless of rr_ptr. Other requesters use round robin as above. rr_ptr is not updated
//   when requester 0 completes.
// - Not defined: pure round robin over all requesters, as in BEHAVIOUR.
// TESTING
// - Single req: req0 a=10,b=5,c=1 -> req_ready[0] in the accept cycle; 2 cycles later
//   resp_valid=1, id=0, result=51.
// - All 4 valid, resp_ready=1, after reset -> grant order 0,1,2,3,0; one grant every 3 cycles;
//   results match a*b+c per id.
// - Wrap: only req3 and req0 valid, rr_ptr=3 -> grant 3 then 0. Saturation, dw=8: a=b=c=255 ->
//   result=65280.
// - Backpressure: resp_ready=0 for 5 cycles with a=25,b=10,c=5 -> result=255 held stable, no new
//   grant, req_ready=0 throughout.
// - Reset mid-op: assert rst_n=0 in EXEC -> resp_valid=0 immediately; after release, no response
//   and rr_ptr=0.
// - DSP_ARB_PRIO_EN: req0 and req2 continuously valid -> req0 granted every time; req2 never
//   granted until req0 drops.

Source files
------------

// File: rtl/dsp_rr_arbiter.sv
// Round-robin front end sharing one external a*b+c dsp_slice among NUM_REQ requesters.
// Define DSP_ARB_PRIO_EN to give requester 0 strict priority over the round robin.
module dsp_rr_arbiter #(
    parameter  int data_width = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*data_width-1:0] req_a,
    input  logic [NUM_REQ*data_width-1:0] req_b,
    input  logic [NUM_REQ*data_width-1:0] req_c,
    output logic [data_width-1:0]         dsp_a,
    output logic [data_width-1:0]         dsp_b,
    output logic [data_width-1:0]         dsp_c,
    input  logic [2*data_width-1:0]       dsp_result,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [2*data_width-1:0]       resp_result
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic [data_width-1:0] a;
        logic [data_width-1:0] b;
        logic [data_width-1:0] c;
    } operand_t;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        op_id;
    operand_t [NUM_REQ-1:0] lane_op;

    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        scan_idx;
    logic [ID_W-1:0]        next_ptr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_op[i].a = req_a[i*data_width +: data_width];
        assign lane_op[i].b = req_b[i*data_width +: data_width];
        assign lane_op[i].c = req_c[i*data_width +: data_width];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
`ifdef DSP_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
            grant_id  = '0;
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_any)
            req_ready[grant_id] = 1'b1;
    end

    assign next_ptr = (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_id       <= '0;
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_c       <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        dsp_a <= lane_op[grant_id].a;
                        dsp_b <= lane_op[grant_id].b;
                        dsp_c <= lane_op[grant_id].c;
                        op_id <= grant_id;
                        state <= EXEC;
                    end
                end
                // Slice is combinational on the registered operands, so its result is settled here.
                EXEC: begin
                    resp_result <= dsp_result;
                    resp_id     <= op_id;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
`ifdef DSP_ARB_PRIO_EN
                        if (resp_id != '0)
                            rr_ptr <= next_ptr;
`else
                        rr_ptr <= next_ptr;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_rr_arbiter.sv
// Bench for dsp_rr_arbiter: directed cases plus random traffic against a transaction-level model.
module tb_dsp_rr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a, req_b, req_c;
    logic [DW-1:0]     dsp_a, dsp_b, dsp_c;
    logic [2*DW-1:0]   dsp_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [2*DW-1:0]   resp_result;
    logic [DW-1:0]     op_a [NR];
    logic [DW-1:0]     op_b [NR];
    logic [DW-1:0]     op_c [NR];

    always #5 clk = ~clk;

    dsp_rr_arbiter #(.data_width(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c),
        .dsp_result(dsp_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result)
    );

    // The external slice.
    assign dsp_result = {{DW{1'b0}}, dsp_a} * {{DW{1'b0}}, dsp_b} + {{DW{1'b0}}, dsp_c};

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
            req_c[i*DW +: DW] = op_c[i];
        end
    end

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    int        cyc = 0;
    int        m_ptr = 0;
    int        m_id = 0;
    int        m_acc = 0;
    int        m_res = 0;
    bit        m_busy = 1'b0;
    bit        m_done = 1'b0;
    int        grant_log [$];
    int        grant_cyc [$];
    logic [NR-1:0] obs_ready = '0;
    bit        last_rv = 1'b0;
    int        last_id = 0;
    int        last_res = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
`ifdef DSP_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    // One clock: inputs already driven at posedge+1; check at negedge; return at next posedge+1.
    task automatic cycle();
        int w;
        logic [NR-1:0] er;
        bit erv;
        @(negedge clk);
        cyc++;
        er = '0;
        obs_ready = req_ready;
        if (!m_busy) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
                er[w]  = 1'b1;
                m_busy = 1'b1;
                m_id   = w;
                m_acc  = cyc;
                m_res  = int'(op_a[w]) * int'(op_b[w]) + int'(op_c[w]);
                grant_log.push_back(w);
                grant_cyc.push_back(cyc);
            end
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        erv = m_busy && (cyc >= m_acc + 2);
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        last_rv = resp_valid;
        if (erv) begin
            chk("resp_id", 32'(resp_id), m_id);
            chk("resp_result", 32'(resp_result), m_res);
            last_id  = int'(resp_id);
            last_res = int'(resp_result);
            if (resp_ready) m_done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
`ifdef DSP_ARB_PRIO_EN
            if (m_id != 0) m_ptr = (m_id + 1) % NR;
`else
            m_ptr = (m_id + 1) % NR;
`endif
        end
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        #1;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ptr  = 0;
        if (check) begin
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            chk("rst_resp_result", 32'(resp_result), 0);
            chk("rst_dsp_abc", {8'd0, dsp_a, dsp_b, dsp_c}, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10 && m_busy; i++) cycle();
    endtask

    task automatic new_op(input int i);
        op_a[i] = ($urandom % 8 == 0) ? DW'(255) : DW'($urandom);
        op_b[i] = ($urandom % 8 == 0) ? DW'(255) : DW'($urandom);
        op_c[i] = ($urandom % 8 == 0) ? DW'(255) : DW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) new_op(i);
        #1;
        do_reset(1'b1);

        // Single request, 10*5+1.
        req_valid = '0;
        op_a[0] = 8'd10; op_b[0] = 8'd5; op_c[0] = 8'd1;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        cycle();
        chk("single_grant", 32'(obs_ready), 32'h1);
        req_valid = '0;
        cycle();
        chk("single_lat1", 32'(last_rv), 0);
        cycle();
        chk("single_valid", 32'(last_rv), 1);
        chk("single_id", last_id, 0);
        chk("single_res", last_res, 51);

        // All requesters valid after reset: 0,1,2,3,0 every 3 cycles.
        do_reset(1'b0);
        for (int i = 0; i < NR; i++) new_op(i);
        grant_log.delete();
        grant_cyc.delete();
        req_valid  = '1;
        resp_ready = 1'b1;
        repeat (14) cycle();
        drain();
        chk("rr_count", 32'(grant_log.size() >= 5), 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            chk("rr_order", grant_log[k], k % NR);
            if (k > 0) chk("rr_gap", grant_cyc[k] - grant_cyc[k-1], 3);
        end

        // Pointer wrap 3 -> 0 with saturated operands.
        do_reset(1'b0);
        new_op(2);
        req_valid = 4'b0100;
        cycle();
        drain();
        op_a[3] = 8'd255; op_b[3] = 8'd255; op_c[3] = 8'd255;
        op_a[0] = 8'd255; op_b[0] = 8'd255; op_c[0] = 8'd255;
        req_valid = 4'b1001;
        cycle();
        chk("wrap_first", 32'(obs_ready), 32'h8);
        req_valid = 4'b0001;
        cycle();
        cycle();
        chk("sat_res3", last_res, 65280);
        cycle();
        chk("wrap_second", 32'(obs_ready), 32'h1);
        drain();
        chk("sat_id0", last_id, 0);
        chk("sat_res0", last_res, 65280);

        // Backpressure: response held for 5 cycles, no new grant.
        op_a[0] = 8'd25; op_b[0] = 8'd10; op_c[0] = 8'd5;
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        cycle();
        new_op(1);
        req_valid = 4'b0010;
        cycle();
        repeat (5) begin
            cycle();
            chk("bp_valid", 32'(last_rv), 1);
            chk("bp_res", last_res, 255);
            chk("bp_ready", 32'(obs_ready), 0);
        end
        resp_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_next_grant", 32'(obs_ready), 32'h2);
        drain();

        // Reset during EXEC: pointer is 2 beforehand and must come back as 0.
        new_op(2);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        do_reset(1'b1);
        repeat (4) cycle();
        req_valid = '1;
        cycle();
        chk("rst_ptr", 32'(obs_ready), 32'h1);
        drain();

        // Reset during RESP drops a visible response.
        new_op(1);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        chk("resp_hold_pre_rst", 32'(last_rv), 1);
        do_reset(1'b1);
        resp_ready = 1'b1;
        repeat (3) cycle();

`ifdef DSP_ARB_PRIO_EN
        do_reset(1'b0);
        new_op(0);
        new_op(2);
        grant_log.delete();
        req_valid  = 4'b0101;
        resp_ready = 1'b1;
        repeat (12) cycle();
        foreach (grant_log[k]) chk("prio_req0", grant_log[k], 0);
        req_valid = 4'b0100;
        repeat (4) cycle();
        chk("prio_req2", grant_log[grant_log.size()-1], 2);
        drain();
`endif

        // Random traffic honouring the hold-until-ready rule.
        req_valid = '0;
        obs_ready = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && obs_ready[i]) begin
                    if ($urandom % 2 == 0) new_op(i);
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom % 20 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req_valid[i] = 1'b1;
                    new_op(i);
                end
            end
            resp_ready = ($urandom % 4) != 0;
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
